// File: rtl/rechannelizer2_pkg.sv
// rtl/rechannelizer2_pkg.sv - shared state encodings and default widths for the rechannelizer stages
package rechannelizer2_pkg;
    localparam int IN_W_DEF  = 24;
    localparam int OUT_W_DEF = 16;

    localparam logic [0:0] ST_WAIT_SOP = 1'b0;
    localparam logic [0:0] ST_WAIT_EOP = 1'b1;
endpackage

// File: rtl/rechannelizer2_pair_fifo2.sv
// rtl/rechannelizer2_pair_fifo2.sv - two-entry pair buffer with a registered head entry
module pair_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    logic [1:0]   count;
    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = mem0;
    assign do_pop  = pop && !empty;
    // a full buffer still takes a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (empty) mem0 <= push_data;
                    else       mem1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // last entry leaving keeps the head value visible
                    if (full) mem0 <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (full) begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end else begin
                        mem0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/rechannelizer2.sv
// rtl/rechannelizer2.sv - re-pairs a 2-beat I/Q packet stream into parallel rounded channel words
module rechannelizer2
    import rechannelizer2_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic [OUT_W-1:0] out_data_1,
    output logic [OUT_W-1:0] out_data_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_framing,
    output logic             err_overflow,
    input  logic             err_clear,
    output logic [CNT_W-1:0] pair_count
);
    logic [0:0]       state;
    logic [OUT_W-1:0] ch1;
    logic [OUT_W-1:0] rnd;
    logic             start_beat;
    logic             push_req;
    logic             frame_bad;
    logic             pop;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [2*OUT_W-1:0] head;

    generate
        if (IN_W == OUT_W) begin : g_pass
            assign rnd = in_data;
        end else begin : g_round
            localparam int SH = IN_W - OUT_W;
            localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SH - 1);
            logic signed [IN_W:0] sum;
            logic signed [IN_W:0] shf;
            logic                 sat;
            assign sum = $signed({in_data[IN_W-1], in_data}) + HALF;
            assign shf = sum >>> SH;
            // only the positive side can exceed the output range after rounding up
            assign sat = !shf[IN_W] && (shf[IN_W-1:OUT_W-1] != '0);
            assign rnd = sat ? {1'b0, {(OUT_W-1){1'b1}}} : shf[OUT_W-1:0];
        end
    endgenerate

    assign start_beat = in_sop && !in_eop;
    assign push_req   = in_valid && (state == ST_WAIT_EOP) && in_eop && !in_sop;
    assign frame_bad  = in_valid && ((state == ST_WAIT_SOP) ? !start_beat : !(in_eop && !in_sop));
    assign pop        = out_valid && out_ready;
    assign overflow   = push_req && full && !pop;

    pair_fifo2 #(.W(2*OUT_W)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data ({ch1, rnd}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign out_valid  = !empty;
    assign out_data_1 = head[2*OUT_W-1:OUT_W];
    assign out_data_2 = head[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_WAIT_SOP;
            ch1          <= '0;
            err_framing  <= 1'b0;
            err_overflow <= 1'b0;
            pair_count   <= '0;
        end else begin
            // every valid beat that is a clean sop starts a packet, from either state
            if (in_valid) begin
                state <= start_beat ? ST_WAIT_EOP : ST_WAIT_SOP;
                if (start_beat) ch1 <= rnd;
            end
            if (push_req && !overflow) pair_count <= pair_count + 1'b1;
            if (err_clear) begin
                err_framing  <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (frame_bad) err_framing  <= 1'b1;
            if (overflow)  err_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rechannelizer2.sv
// tb/tb_rechannelizer2.sv - directed vector bench for rechannelizer2
module tb_rechannelizer2;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [15:0] out_data_1;
    logic [15:0] out_data_2;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err_framing;
    logic        err_overflow;
    logic        err_clear = 1'b0;
    logic [15:0] pair_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [23:0] i_in;
        logic [23:0] q_in;
        logic [15:0] i_exp;
        logic [15:0] q_exp;
    } vec_t;

    vec_t vecs [8];

    rechannelizer2 #(.IN_W(24), .OUT_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_framing  (err_framing),
        .err_overflow (err_overflow),
        .err_clear    (err_clear),
        .pair_count   (pair_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [23:0] d, input logic s, input logic e);
        in_data  = d;
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        err_clear = 1'b0;
        in_valid  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{24'h000080, 24'hFFFF7F, 16'h0001, 16'hFFFF};
        vecs[1] = '{24'h7FFF80, 24'h800000, 16'h7FFF, 16'h8000};
        vecs[2] = '{24'h123456, 24'h123480, 16'h1234, 16'h1235};
        vecs[3] = '{24'hFFFFFF, 24'h000000, 16'h0000, 16'h0000};
        vecs[4] = '{24'h7FFFFF, 24'h80007F, 16'h7FFF, 16'h8000};
        vecs[5] = '{24'h7FFF7F, 24'h000180, 16'h7FFF, 16'h0002};
        vecs[6] = '{24'hFFFE80, 24'h00017F, 16'hFFFF, 16'h0001};
        vecs[7] = '{24'h400000, 24'hC00000, 16'h4000, 16'hC000};

        do_reset();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_d1", {16'd0, out_data_1}, 32'd0);
        chk("reset_d2", {16'd0, out_data_2}, 32'd0);
        chk("reset_errf", {31'd0, err_framing}, 32'd0);
        chk("reset_erro", {31'd0, err_overflow}, 32'd0);
        chk("reset_cnt", {16'd0, pair_count}, 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat(vecs[i].i_in, 1'b1, 1'b0);
            beat(vecs[i].q_in, 1'b0, 1'b1);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_d1", i), {16'd0, out_data_1}, {16'd0, vecs[i].i_exp});
            chk($sformatf("vec%0d_d2", i), {16'd0, out_data_2}, {16'd0, vecs[i].q_exp});
            chk($sformatf("vec%0d_cnt", i), {16'd0, pair_count}, i + 1);
            tick();
            chk($sformatf("vec%0d_popped", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("vec%0d_hold", i), {16'd0, out_data_1}, {16'd0, vecs[i].i_exp});
        end
        chk("vec_errf", {31'd0, err_framing}, 32'd0);
        chk("vec_erro", {31'd0, err_overflow}, 32'd0);

        // sop, sop, eop: first ch1 lost
        do_reset();
        out_ready = 1'b1;
        beat(24'h000100, 1'b1, 1'b0);
        beat(24'h000200, 1'b1, 1'b0);
        beat(24'h000300, 1'b0, 1'b1);
        chk("resop_valid", {31'd0, out_valid}, 32'd1);
        chk("resop_d1", {16'd0, out_data_1}, 32'h0002);
        chk("resop_d2", {16'd0, out_data_2}, 32'h0003);
        chk("resop_errf", {31'd0, err_framing}, 32'd1);
        chk("resop_cnt", {16'd0, pair_count}, 32'd1);
        tick();
        chk("resop_single", {31'd0, out_valid}, 32'd0);

        // sop&eop in WAIT_EOP and idle beat in WAIT_EOP both abort the packet
        do_reset();
        beat(24'h000100, 1'b1, 1'b0);
        beat(24'h000200, 1'b1, 1'b1);
        beat(24'h000300, 1'b0, 1'b1);
        beat(24'h000400, 1'b1, 1'b0);
        beat(24'h000500, 1'b0, 1'b0);
        beat(24'h000600, 1'b0, 1'b1);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_cnt", {16'd0, pair_count}, 32'd0);
        chk("abort_errf", {31'd0, err_framing}, 32'd1);

        // overflow with consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            beat(24'(p * 2 + 1) << 8, 1'b1, 1'b0);
            beat(24'(p * 2 + 2) << 8, 1'b0, 1'b1);
        end
        chk("ovf_valid", {31'd0, out_valid}, 32'd1);
        chk("ovf_d1", {16'd0, out_data_1}, 32'h0001);
        chk("ovf_d2", {16'd0, out_data_2}, 32'h0002);
        chk("ovf_erro", {31'd0, err_overflow}, 32'd1);
        chk("ovf_errf", {31'd0, err_framing}, 32'd0);
        chk("ovf_cnt", {16'd0, pair_count}, 32'd2);
        out_ready = 1'b1;
        tick();
        chk("ovf_pop1_valid", {31'd0, out_valid}, 32'd1);
        chk("ovf_pop1_d1", {16'd0, out_data_1}, 32'h0003);
        chk("ovf_pop1_d2", {16'd0, out_data_2}, 32'h0004);
        tick();
        chk("ovf_pop2_valid", {31'd0, out_valid}, 32'd0);
        chk("ovf_pop2_hold", {16'd0, out_data_2}, 32'h0004);

        // push into a full buffer while popping, then push+pop at one entry
        do_reset();
        out_ready = 1'b0;
        beat(24'h000100, 1'b1, 1'b0);
        beat(24'h000200, 1'b0, 1'b1);
        beat(24'h000300, 1'b1, 1'b0);
        beat(24'h000400, 1'b0, 1'b1);
        beat(24'h000500, 1'b1, 1'b0);
        out_ready = 1'b1;
        beat(24'h000600, 1'b0, 1'b1);
        chk("fullpp_erro", {31'd0, err_overflow}, 32'd0);
        chk("fullpp_cnt", {16'd0, pair_count}, 32'd3);
        chk("fullpp_d1", {16'd0, out_data_1}, 32'h0003);
        out_ready = 1'b0;
        tick();
        chk("fullpp_keep", {16'd0, out_data_1}, 32'h0003);
        out_ready = 1'b1;
        tick();
        chk("fullpp_next", {16'd0, out_data_1}, 32'h0005);
        chk("fullpp_d2", {16'd0, out_data_2}, 32'h0006);
        out_ready = 1'b0;
        beat(24'h000700, 1'b1, 1'b0);
        out_ready = 1'b1;
        beat(24'h000800, 1'b0, 1'b1);
        chk("onepp_valid", {31'd0, out_valid}, 32'd1);
        chk("onepp_d1", {16'd0, out_data_1}, 32'h0007);
        tick();
        chk("onepp_empty", {31'd0, out_valid}, 32'd0);
        chk("onepp_cnt", {16'd0, pair_count}, 32'd4);

        // reset between sop and eop
        do_reset();
        beat(24'h000100, 1'b1, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        beat(24'h000200, 1'b0, 1'b1);
        chk("midrst_errf", {31'd0, err_framing}, 32'd1);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_d1", {16'd0, out_data_1}, 32'd0);
        chk("midrst_d2", {16'd0, out_data_2}, 32'd0);
        chk("midrst_cnt", {16'd0, pair_count}, 32'd0);

        // clear colliding with a new error, then clear alone
        err_clear = 1'b1;
        beat(24'h000300, 1'b0, 1'b1);
        chk("clr_collide", {31'd0, err_framing}, 32'd1);
        tick();
        err_clear = 1'b0;
        chk("clr_alone", {31'd0, err_framing}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
